// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer: classifies each raster pixel as control, video or
// data-island period and drives the TMDS mode/CTL bus plus the packetizer handshake.
module hdmi_period_scheduler #(
    parameter int H_ACTIVE     = 720,
    parameter int H_TOTAL      = 858,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int H_SYNC_START = 736,
    parameter int H_SYNC_END   = 798,
    parameter int V_SYNC_START = 489,
    parameter int V_SYNC_END   = 495,
    parameter int ISLAND_START = 740,
    parameter int MAX_PACKETS  = 2
) (
    input  logic       pixelClock,
    input  logic       reset,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    input  logic       packetValid,
    output logic [2:0] encMode,
    output logic [3:0] ctl,
    output logic       hSync,
    output logic       vSync,
    output logic [4:0] packetPixel,
    output logic       packetAccept,
    output logic       islandFirst
);

    typedef enum logic [2:0] {
        CTRL, ISL_PRE, ISL_LGB, ISL_PKT, ISL_TGB, VID_PRE, VID_GB, VIDEO
    } state_t;

    localparam logic [2:0] MODE_CTRL      = 3'd0;
    localparam logic [2:0] MODE_VIDEO     = 3'd1;
    localparam logic [2:0] MODE_VIDEO_GB  = 3'd2;
    localparam logic [2:0] MODE_ISLAND    = 3'd3;
    localparam logic [2:0] MODE_ISLAND_GB = 3'd4;

    localparam logic [9:0] LP_H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] LP_VID_START  = 10'(H_TOTAL - 10);
    localparam logic [9:0] LP_V_ACT_M1   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] LP_V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] LP_ISL_START  = 10'(ISLAND_START);
    localparam logic [9:0] LP_HS_START   = 10'(H_SYNC_START);
    localparam logic [9:0] LP_HS_END     = 10'(H_SYNC_END);
    localparam logic [9:0] LP_VS_START   = 10'(V_SYNC_START);
    localparam logic [9:0] LP_VS_END     = 10'(V_SYNC_END);
    localparam logic [2:0] LP_MORE_LIMIT = 3'(MAX_PACKETS - 1);

    // Islands must fit between active video and the next video preamble.
    if (!(ISLAND_START + 12 + 32 * MAX_PACKETS + 12 <= H_TOTAL - 10 &&
          ISLAND_START >= H_ACTIVE + 12 && MAX_PACKETS >= 1 && MAX_PACKETS <= 4)) begin : g_bad_params
        $error("hdmi_period_scheduler: island does not fit in horizontal blanking");
    end

    state_t     r_state;
    logic [3:0] r_phase;
    logic [4:0] r_pix;
    logic [2:0] r_count;

    logic w_prev_line, w_vid_start, w_isl_start, w_hsync, w_vsync;

    assign w_prev_line = (vPos == LP_V_LAST) || (vPos < LP_V_ACT_M1);
    assign w_vid_start = w_prev_line && (hPos == LP_VID_START);
    assign w_isl_start = packetValid && (hPos == LP_ISL_START);
    assign w_hsync     = (hPos >= LP_HS_START) && (hPos <= LP_HS_END);
    assign w_vsync     = (vPos >= LP_VS_START) && (vPos <= LP_VS_END);

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_state      <= CTRL;
            r_phase      <= '0;
            r_pix        <= '0;
            r_count      <= '0;
            encMode      <= MODE_CTRL;
            ctl          <= '0;
            hSync        <= 1'b0;
            vSync        <= 1'b0;
            packetPixel  <= '0;
            packetAccept <= 1'b0;
            islandFirst  <= 1'b0;
        end else begin
            hSync        <= w_hsync;
            vSync        <= w_vsync;
            // NOTE: defaults first so pulse-style outputs drop unless the current state re-asserts them.
            encMode      <= MODE_CTRL;
            ctl          <= '0;
            packetPixel  <= '0;
            packetAccept <= 1'b0;
            islandFirst  <= 1'b0;
            case (r_state)
                CTRL: begin
                    if (w_vid_start) begin
                        ctl     <= 4'b0001;
                        r_state <= VID_PRE;
                        r_phase <= 4'd1;
                    end else if (w_isl_start) begin
                        ctl     <= 4'b0101;
                        r_state <= ISL_PRE;
                        r_phase <= 4'd1;
                        r_count <= '0;
                    end
                end
                VID_PRE: begin
                    ctl     <= 4'b0001;
                    r_phase <= r_phase + 4'd1;
                    if (r_phase == 4'd7) begin
                        r_state <= VID_GB;
                        r_phase <= '0;
                    end
                end
                VID_GB: begin
                    encMode <= MODE_VIDEO_GB;
                    r_phase <= r_phase + 4'd1;
                    if (r_phase == 4'd1) r_state <= VIDEO;
                end
                VIDEO: begin
                    encMode <= MODE_VIDEO;
                    if (hPos == LP_H_ACT_LAST) r_state <= CTRL;
                end
                ISL_PRE: begin
                    ctl     <= 4'b0101;
                    r_phase <= r_phase + 4'd1;
                    if (r_phase == 4'd7) begin
                        r_state <= ISL_LGB;
                        r_phase <= '0;
                    end
                end
                ISL_LGB: begin
                    encMode <= MODE_ISLAND_GB;
                    r_phase <= r_phase + 4'd1;
                    if (r_phase == 4'd1) begin
                        r_state <= ISL_PKT;
                        r_pix   <= '0;
                    end
                end
                ISL_PKT: begin
                    encMode     <= MODE_ISLAND;
                    packetPixel <= r_pix;
                    islandFirst <= (r_pix == 5'd0) && (r_count == 3'd0);
                    r_pix       <= r_pix + 5'd1;
                    if (r_pix == 5'd31) begin
                        // r_count holds packets finished before this one.
                        packetAccept <= 1'b1;
                        r_count      <= r_count + 3'd1;
                        if (!(packetValid && r_count < LP_MORE_LIMIT)) begin
                            r_state <= ISL_TGB;
                            r_phase <= '0;
                        end
                    end
                end
                ISL_TGB: begin
                    encMode <= MODE_ISLAND_GB;
                    r_phase <= r_phase + 4'd1;
                    if (r_phase == 4'd1) r_state <= CTRL;
                end
                default: r_state <= CTRL;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: drives raster segments with random packetValid and
// compares every registered output against an offset-based period model.
module tb_hdmi_period_scheduler;

    localparam int H_TOTAL = 858;
    localparam int V_TOTAL = 525;
    localparam int MAXP    = 2;

    logic       pixelClock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] hPos = '0;
    logic [9:0] vPos = '0;
    logic       packetValid = 1'b0;
    logic [2:0] encMode;
    logic [3:0] ctl;
    logic       hSync, vSync;
    logic [4:0] packetPixel;
    logic       packetAccept, islandFirst;

    hdmi_period_scheduler dut (
        .pixelClock  (pixelClock),
        .reset       (reset),
        .hPos        (hPos),
        .vPos        (vPos),
        .packetValid (packetValid),
        .encMode     (encMode),
        .ctl         (ctl),
        .hSync       (hSync),
        .vSync       (vSync),
        .packetPixel (packetPixel),
        .packetAccept(packetAccept),
        .islandFirst (islandFirst)
    );

    always #5 pixelClock = ~pixelClock;

    int checks = 0;
    int failures = 0;
    int cur_h = 0, cur_v = 0, p_h = 0, p_v = 0;

    // Model state: video armed by a preamble, island in progress with packets committed.
    bit mv_on = 0;
    bit mi_on = 0;
    int mi_npk = 0;

    logic [15:0] exp_vec;
    logic [15:0] got_vec;
    assign got_vec = {encMode, ctl, hSync, vSync, packetPixel, packetAccept, islandFirst};

    task automatic model_pixel(input int h, input int v, input bit pv, input bit rst);
        logic [2:0] m = 3'd0;
        logic [3:0] c = 4'd0;
        logic [4:0] pp = 5'd0;
        bit acc = 0, first = 0, hs, vs;
        int off, pkt_end;
        hs = (h >= 736 && h <= 798);
        vs = (v >= 489 && v <= 495);
        if (rst) begin
            mv_on = 0;
            mi_on = 0;
            exp_vec = '0;
            return;
        end
        if (!mv_on && !mi_on && h == H_TOTAL - 10 && (v == V_TOTAL - 1 || v < 479)) mv_on = 1;
        if (mv_on) begin
            if (h >= 848 && h <= 855) c = 4'b0001;
            else if (h >= 856) m = 3'd2;
            else if (h < 720) begin
                m = 3'd1;
                if (h == 719) mv_on = 0;
            end
        end else if (!mi_on && h == 740 && pv) begin
            mi_on = 1;
            mi_npk = 1;
        end
        if (mi_on) begin
            off = h - 740;
            pkt_end = 10 + 32 * mi_npk;
            if (off < 8) c = 4'b0101;
            else if (off < 10) m = 3'd4;
            else if (off < pkt_end) begin
                m = 3'd3;
                pp = 5'((off - 10) % 32);
                first = (off == 10);
                if ((off - 10) % 32 == 31) begin
                    acc = 1;
                    if (pv && mi_npk < MAXP) mi_npk++;
                end
            end else begin
                m = 3'd4;
                if (off == pkt_end + 1) mi_on = 0;
            end
        end
        exp_vec = {m, c, hs, vs, pp, acc, first};
    endtask

    // Present the pixel at (cur_h, cur_v), advance the raster, sample #1 after the edge.
    task automatic tick(input bit pv, input bit rst);
        hPos = 10'(cur_h);
        vPos = 10'(cur_v);
        packetValid = pv;
        reset = rst;
        model_pixel(cur_h, cur_v, pv, rst);
        p_h = cur_h;
        p_v = cur_v;
        cur_h++;
        if (cur_h == H_TOTAL) begin
            cur_h = 0;
            cur_v = (cur_v + 1) % V_TOTAL;
        end
        @(posedge pixelClock);
        #1;
    endtask

    task automatic start_at(input int h, input int v);
        cur_h = h;
        cur_v = v;
        tick(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            cur_h = int'($urandom_range(0, H_TOTAL - 1));
            cur_v = int'($urandom_range(0, V_TOTAL - 1));
            tick(1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (got_vec !== 16'h0000 || got_vec !== exp_vec) begin
                failures++;
                $display("FAIL reset_state h=%0d v=%0d got=%h exp=%h", p_h, p_v, got_vec, 16'h0000);
            end
        end
    endtask

    task automatic test_video_raster();
        int n_pre = 0, n_gb = 0, n_vid = 0, n_hs = 0, n_isl = 0, first_pre = -1;
        start_at(700, 524);
        while (!(cur_v == 1 && cur_h == 10)) begin
            tick(1'b0, 1'b0);
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL video_raster h=%0d v=%0d got=%h exp=%h", p_h, p_v, got_vec, exp_vec);
            end
            if (p_v == 524 && ctl == 4'b0001) begin
                n_pre++;
                if (first_pre < 0) first_pre = p_h;
            end
            if (p_v == 524 && encMode == 3'd2) n_gb++;
            if (p_v == 0 && encMode == 3'd1) n_vid++;
            if (p_v == 0 && hSync) n_hs++;
            if (encMode >= 3'd3) n_isl++;
        end
        checks++;
        if (n_pre != 8 || first_pre != 848 || n_gb != 2) begin
            failures++;
            $display("FAIL video_preamble count=%0d first=%0d gb=%0d exp 8/848/2", n_pre, first_pre, n_gb);
        end
        checks++;
        if (n_vid != 720 || n_hs != 63 || n_isl != 0) begin
            failures++;
            $display("FAIL video_line vid=%0d hs=%0d isl=%0d exp 720/63/0", n_vid, n_hs, n_isl);
        end
    endtask

    task automatic test_island_two();
        int n_acc = 0, acc_h[2], first_h = -1;
        acc_h[0] = -1;
        acc_h[1] = -1;
        start_at(700, 500);
        while (cur_h != 830) begin
            tick(1'b1, 1'b0);
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL island_two h=%0d v=%0d got=%h exp=%h", p_h, p_v, got_vec, exp_vec);
            end
            if (packetAccept) begin
                if (n_acc < 2) acc_h[n_acc] = p_h;
                n_acc++;
            end
            if (islandFirst) first_h = p_h;
        end
        checks++;
        if (n_acc != 2 || acc_h[0] != 781 || acc_h[1] != 813 || first_h != 750) begin
            failures++;
            $display("FAIL island_accepts n=%0d at %0d,%0d first=%0d exp 2 at 781,813 first=750",
                     n_acc, acc_h[0], acc_h[1], first_h);
        end
    endtask

    task automatic test_single_packet();
        int n_acc = 0, last_gb = -1;
        start_at(700, 501);
        while (cur_h != 830) begin
            tick(cur_h < 781, 1'b0);
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL single_packet h=%0d v=%0d got=%h exp=%h", p_h, p_v, got_vec, exp_vec);
            end
            if (packetAccept) n_acc++;
            if (encMode == 3'd4) last_gb = p_h;
        end
        checks++;
        if (n_acc != 1 || last_gb != 783) begin
            failures++;
            $display("FAIL single_packet_end acc=%0d last_gb=%0d exp 1/783", n_acc, last_gb);
        end
    endtask

    task automatic test_late_valid();
        int n_isl_a = 0, n_acc_b = 0, start_b = -1;
        start_at(700, 502);
        while (!(cur_v == 503 && cur_h == 830)) begin
            tick(!(cur_v == 502 && cur_h < 741), 1'b0);
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL late_valid h=%0d v=%0d got=%h exp=%h", p_h, p_v, got_vec, exp_vec);
            end
            if (p_v == 502 && (encMode != 3'd0 || ctl != 4'd0)) n_isl_a++;
            if (p_v == 503 && packetAccept) n_acc_b++;
            if (p_v == 503 && ctl == 4'b0101 && start_b < 0) start_b = p_h;
        end
        checks++;
        if (n_isl_a != 0 || n_acc_b != 2 || start_b != 740) begin
            failures++;
            $display("FAIL late_valid_lines isl_a=%0d acc_b=%0d start_b=%0d exp 0/2/740",
                     n_isl_a, n_acc_b, start_b);
        end
    endtask

    task automatic test_reset_mid();
        int n_acc_a = 0, n_acc_b = 0;
        start_at(700, 503);
        while (!(cur_v == 504 && cur_h == 830)) begin
            tick(1'b1, cur_v == 503 && cur_h == 760);
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL reset_mid h=%0d v=%0d got=%h exp=%h", p_h, p_v, got_vec, exp_vec);
            end
            if (p_v == 503 && p_h == 760) begin
                checks++;
                if (got_vec !== 16'h0000) begin
                    failures++;
                    $display("FAIL reset_mid_zero got=%h exp=0000", got_vec);
                end
            end
            if (packetAccept) begin
                if (p_v == 503) n_acc_a++;
                else n_acc_b++;
            end
        end
        checks++;
        if (n_acc_a != 0 || n_acc_b != 2) begin
            failures++;
            $display("FAIL reset_mid_accepts partial=%0d next=%0d exp 0/2", n_acc_a, n_acc_b);
        end
    endtask

    task automatic test_line_boundaries();
        int pre_478 = 0, pre_479 = 0, vid_479 = 0;
        int vs_line[9];
        start_at(830, 478);
        while (!(cur_v == 480 && cur_h == 10)) begin
            tick(1'b0, 1'b0);
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL line_479 h=%0d v=%0d got=%h exp=%h", p_h, p_v, got_vec, exp_vec);
            end
            if (ctl == 4'b0001) begin
                if (p_v == 478) pre_478++;
                if (p_v == 479) pre_479++;
            end
            if (p_v == 479 && encMode == 3'd1) vid_479++;
        end
        checks++;
        if (pre_478 != 8 || pre_479 != 0 || vid_479 != 720) begin
            failures++;
            $display("FAIL line_479_sched pre478=%0d pre479=%0d vid479=%0d exp 8/0/720",
                     pre_478, pre_479, vid_479);
        end
        for (int i = 0; i < 9; i++) vs_line[i] = 0;
        start_at(0, 488);
        while (!(cur_v == 497 && cur_h == 0)) begin
            tick(1'b0, 1'b0);
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL vsync_run h=%0d v=%0d got=%h exp=%h", p_h, p_v, got_vec, exp_vec);
            end
            if (vSync) vs_line[p_v - 488]++;
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (vs_line[i] != ((i >= 1 && i <= 7) ? H_TOTAL : 0)) begin
                failures++;
                $display("FAIL vsync_line v=%0d high=%0d exp=%0d", 488 + i, vs_line[i],
                         (i >= 1 && i <= 7) ? H_TOTAL : 0);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            start_at(720, int'($urandom_range(0, V_TOTAL - 1)));
            for (int n = 0; n < 4 * H_TOTAL; n++) begin
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 1999) == 0);
                checks++;
                if (got_vec !== exp_vec) begin
                    failures++;
                    $display("FAIL random h=%0d v=%0d got=%h exp=%h", p_h, p_v, got_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_video_raster();
        test_island_two();
        test_single_packet();
        test_late_valid();
        test_reset_mid();
        test_line_boundaries();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
